flexbus_master: RTL and testbench

Synthesizable FlexBus initiator that issues single 32-bit multiplexed-address/data read and write cycles onto FB_AD/FB_ALE/FB_CS/FB_RW. It is the initiator end of the same bus served by perip_flexbus on the PL side. Uses: a PL-side bus driver for loopback/self-test, and the bus-functional master in the testbench. Requests arrive on a simple valid/ready interface; one response per request.

---
 rtl/flexbus_pkg.sv | 26 ++
 rtl/flexbus_if.sv | 28 ++
 rtl/flexbus_master.sv | 148 ++++++++++++++
 tb/tb_flexbus_master.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/flexbus_pkg.sv
// Shared definitions for the FlexBus initiator: state encoding, bus polarities
// and the chip-select window check.
package flexbus_pkg;

   localparam int   FB_DW        = 32;
   localparam logic FB_CS_ACTIVE = 1'b0;
   localparam logic FB_RW_READ   = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_DATA = 3'd2,
      ST_END  = 3'd3,
      ST_ERR  = 3'd4
   } fb_state_t;

   // Unsigned offset compare, so addresses below the base wrap to huge offsets.
   function automatic logic fb_in_window(input logic [FB_DW-1:0] addr,
                                         input logic [FB_DW-1:0] base,
                                         input logic [FB_DW-1:0] span);
      logic [FB_DW-1:0] w_off;
      w_off = addr - base;
      return (w_off < span);
   endfunction

endpackage

// File: rtl/flexbus_if.sv
// Request/response handshake plus FlexBus control strobes; FB_AD stays a
// plain inout on the master so its tri-state driver lives in one place.
interface flexbus_if;
   import flexbus_pkg::*;

   logic             req_valid;
   logic             req_ready;
   logic             req_rw;
   logic [FB_DW-1:0] req_addr;
   logic [FB_DW-1:0] req_wdata;
   logic             rsp_valid;
   logic             rsp_err;
   logic [FB_DW-1:0] rsp_rdata;
   logic             FB_RW;
   logic             FB_CS;
   logic             FB_ALE;

   modport master (
      input  req_valid, req_rw, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_err, rsp_rdata, FB_RW, FB_CS, FB_ALE
   );

   modport slave (
      output req_valid, req_rw, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata, FB_RW, FB_CS, FB_ALE
   );

endinterface

// File: rtl/flexbus_master.sv
// FlexBus initiator: single 32-bit multiplexed address/data read and write
// cycles, one response per accepted request, all outputs registered.
module flexbus_master
   import flexbus_pkg::*;
#(
   parameter logic [31:0] FB_BASE     = 32'h6000_0000,
   parameter logic [31:0] FB_SPAN     = 32'h0001_0000,
   parameter int          WAIT_STATES = 1
) (
   input  logic             FB_CLK,
   input  logic             RST_n,
   flexbus_if.master        bus,
   inout  wire [FB_DW-1:0]  FB_AD
);

   localparam logic [3:0] WS_LAST = 4'(WAIT_STATES);

   fb_state_t        r_state, w_state;
   logic [3:0]       r_cnt, w_cnt;
   logic             r_rw, w_rw;
   logic [FB_DW-1:0] r_wdata, w_wdata;
   logic             r_req_ready, w_req_ready;
   logic             r_rsp_valid, w_rsp_valid;
   logic             r_rsp_err, w_rsp_err;
   logic [FB_DW-1:0] r_rsp_rdata, w_rsp_rdata;
   logic             r_fb_rw, w_fb_rw;
   logic             r_fb_cs, w_fb_cs;
   logic             r_fb_ale, w_fb_ale;
   logic             r_ad_oe, w_ad_oe;
   logic [FB_DW-1:0] r_ad_out, w_ad_out;
   logic [FB_DW-1:0] w_ad_in;

   assign w_ad_in = FB_AD;

   // Next state plus the value every registered output takes in that state.
   always_comb begin
      w_state     = r_state;
      w_cnt       = r_cnt;
      w_rw        = r_rw;
      w_wdata     = r_wdata;
      w_req_ready = 1'b0;
      w_rsp_valid = 1'b0;
      w_rsp_err   = 1'b0;
      w_rsp_rdata = {FB_DW{1'b0}};
      w_fb_rw     = FB_RW_READ;
      w_fb_cs     = ~FB_CS_ACTIVE;
      w_fb_ale    = 1'b0;
      w_ad_oe     = 1'b0;
      w_ad_out    = r_ad_out;
      case (r_state)
         ST_IDLE: begin
            if (bus.req_valid && r_req_ready) begin
               w_rw    = bus.req_rw;
               w_wdata = bus.req_wdata;
               if (fb_in_window(bus.req_addr, FB_BASE, FB_SPAN)) begin
                  w_state  = ST_ADDR;
                  w_fb_ale = 1'b1;
                  w_fb_rw  = bus.req_rw;
                  w_ad_oe  = 1'b1;
                  w_ad_out = bus.req_addr;
               end else begin
                  w_state     = ST_ERR;
                  w_rsp_valid = 1'b1;
                  w_rsp_err   = 1'b1;
               end
            end else begin
               w_req_ready = 1'b1;
            end
         end
         ST_ADDR: begin
            w_state  = ST_DATA;
            w_cnt    = 4'd0;
            w_fb_cs  = FB_CS_ACTIVE;
            w_fb_rw  = r_rw;
            w_ad_oe  = (r_rw != FB_RW_READ);
            w_ad_out = r_wdata;
         end
         ST_DATA: begin
            if (r_cnt == WS_LAST) begin
               // Read data is captured on the edge that closes the last data cycle.
               w_state     = ST_END;
               w_rsp_valid = 1'b1;
               if (r_rw == FB_RW_READ) begin
                  w_rsp_rdata = w_ad_in;
               end else begin
                  w_rsp_rdata = {FB_DW{1'b0}};
               end
            end else begin
               w_cnt   = r_cnt + 4'd1;
               w_fb_cs = FB_CS_ACTIVE;
               w_fb_rw = r_rw;
               w_ad_oe = (r_rw != FB_RW_READ);
            end
         end
         ST_END, ST_ERR: begin
            w_state     = ST_IDLE;
            w_req_ready = 1'b1;
         end
         default: begin
            w_state     = ST_IDLE;
            w_req_ready = 1'b1;
         end
      endcase
   end

   // State and output registers; reset releases the bus on the same edge.
   always_ff @(posedge FB_CLK) begin
      if (!RST_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         r_rw        <= FB_RW_READ;
         r_wdata     <= {FB_DW{1'b0}};
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= {FB_DW{1'b0}};
         r_fb_rw     <= FB_RW_READ;
         r_fb_cs     <= ~FB_CS_ACTIVE;
         r_fb_ale    <= 1'b0;
         r_ad_oe     <= 1'b0;
         r_ad_out    <= {FB_DW{1'b0}};
      end else begin
         r_state     <= w_state;
         r_cnt       <= w_cnt;
         r_rw        <= w_rw;
         r_wdata     <= w_wdata;
         r_req_ready <= w_req_ready;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_err   <= w_rsp_err;
         r_rsp_rdata <= w_rsp_rdata;
         r_fb_rw     <= w_fb_rw;
         r_fb_cs     <= w_fb_cs;
         r_fb_ale    <= w_fb_ale;
         r_ad_oe     <= w_ad_oe;
         r_ad_out    <= w_ad_out;
      end
   end

   assign bus.req_ready = r_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.FB_RW     = r_fb_rw;
   assign bus.FB_CS     = r_fb_cs;
   assign bus.FB_ALE    = r_fb_ale;
   assign FB_AD         = r_ad_oe ? r_ad_out : {FB_DW{1'bz}};

endmodule

// File: tb/tb_flexbus_master.sv
// Directed bench for flexbus_master with a behavioural FlexBus responder,
// a response scoreboard and per-cycle bus checks.
module tb_flexbus_master;
   import flexbus_pkg::*;

   localparam int N = 2;   // data-phase cycles for WAIT_STATES = 1

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          checks = 0;
   int          errors = 0;
   rsp_t        sb[$];

   flexbus_if   fb();
   wire  [31:0] fb_ad;
   logic        tb_ad_oe;
   logic [31:0] tb_ad_val;
   logic [31:0] resp_addr_r;
   logic [31:0] resp_reg0_r;

   always #5 clk = ~clk;

   flexbus_master #(
      .FB_BASE(32'h6000_0000),
      .FB_SPAN(32'h0001_0000),
      .WAIT_STATES(1)
   ) dut (
      .FB_CLK(clk),
      .RST_n(rst_n),
      .bus(fb),
      .FB_AD(fb_ad)
   );

   // Responder: one register at offset 0, fixed pattern elsewhere.
   assign tb_ad_oe  = rst_n && (fb.FB_CS == 1'b0) && (fb.FB_RW == 1'b1);
   assign tb_ad_val = (resp_addr_r[15:0] == 16'h0000) ? resp_reg0_r : 32'h1234_5678;
   assign fb_ad     = tb_ad_oe ? tb_ad_val : {32{1'bz}};

   always @(posedge clk) begin
      if (!rst_n) begin
         resp_addr_r <= 32'h0;
         resp_reg0_r <= 32'h0;
      end else begin
         if (fb.FB_ALE) resp_addr_r <= fb_ad;
         if (!fb.FB_CS && !fb.FB_RW && resp_addr_r[15:0] == 16'h0000) resp_reg0_r <= fb_ad;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor and bus invariants.
   always @(negedge clk) begin
      rsp_t e;
      chk("cs_ale_exclusive", {31'b0, (!fb.FB_CS && fb.FB_ALE)}, 32'h0);
      chk("ad_single_driver", {31'b0, (dut.r_ad_oe && tb_ad_oe)}, 32'h0);
      if (fb.rsp_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: actual err=%0b rdata=%0h required no response",
                     fb.rsp_err, fb.rsp_rdata);
         end else begin
            e = sb.pop_front();
            chk("rsp_err", {31'b0, fb.rsp_err}, {31'b0, e.err});
            chk("rsp_rdata", fb.rsp_rdata, e.rdata);
         end
      end
   end

   // Issue one request and check the bus cycle by cycle; returns at the
   // falling edge of the IDLE cycle that follows the response.
   task automatic txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_err, input logic [31:0] exp_rdata, input logic hold);
      int t = 0;
      fb.req_valid = 1'b1;
      fb.req_rw    = rw;
      fb.req_addr  = addr;
      fb.req_wdata = wdata;
      while (!fb.req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!fb.req_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: actual req_ready=0 required 1");
         fb.req_valid = 1'b0;
         return;
      end
      sb.push_back(rsp_t'({exp_err, exp_rdata}));
      @(negedge clk);
      if (!hold) fb.req_valid = 1'b0;
      if (exp_err) begin
         chk("err_cs", {31'b0, fb.FB_CS}, 32'h1);
         chk("err_ale", {31'b0, fb.FB_ALE}, 32'h0);
         chk("err_ad_oe", {31'b0, dut.r_ad_oe}, 32'h0);
         chk("err_rsp_valid", {31'b0, fb.rsp_valid}, 32'h1);
         chk("err_ready", {31'b0, fb.req_ready}, 32'h0);
      end else begin
         chk("addr_ale", {31'b0, fb.FB_ALE}, 32'h1);
         chk("addr_cs", {31'b0, fb.FB_CS}, 32'h1);
         chk("addr_rw", {31'b0, fb.FB_RW}, {31'b0, rw});
         chk("addr_ad_oe", {31'b0, dut.r_ad_oe}, 32'h1);
         chk("addr_ad", fb_ad, addr);
         chk("addr_ready", {31'b0, fb.req_ready}, 32'h0);
         for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("data_ale", {31'b0, fb.FB_ALE}, 32'h0);
            chk("data_cs", {31'b0, fb.FB_CS}, 32'h0);
            chk("data_rw", {31'b0, fb.FB_RW}, {31'b0, rw});
            chk("data_ready", {31'b0, fb.req_ready}, 32'h0);
            chk("data_rsp_valid", {31'b0, fb.rsp_valid}, 32'h0);
            if (rw) begin
               chk("data_rd_ad_oe", {31'b0, dut.r_ad_oe}, 32'h0);
            end else begin
               chk("data_wr_ad_oe", {31'b0, dut.r_ad_oe}, 32'h1);
               chk("data_wr_ad", fb_ad, wdata);
            end
         end
         @(negedge clk);
         chk("end_cs", {31'b0, fb.FB_CS}, 32'h1);
         chk("end_ale", {31'b0, fb.FB_ALE}, 32'h0);
         chk("end_ad_released", {31'b0, (dut.r_ad_oe || tb_ad_oe)}, 32'h0);
         chk("end_rsp_valid", {31'b0, fb.rsp_valid}, 32'h1);
      end
      @(negedge clk);
      chk("idle_ready", {31'b0, fb.req_ready}, 32'h1);
      chk("idle_rsp_valid", {31'b0, fb.rsp_valid}, 32'h0);
      chk("idle_ad_oe", {31'b0, dut.r_ad_oe}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      fb.req_valid = 1'b0;
      fb.req_rw    = 1'b0;
      fb.req_addr  = 32'h0;
      fb.req_wdata = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'b0, fb.req_ready}, 32'h1);
      chk("rst_rsp_valid", {31'b0, fb.rsp_valid}, 32'h0);
      chk("rst_rsp_err", {31'b0, fb.rsp_err}, 32'h0);
      chk("rst_rsp_rdata", fb.rsp_rdata, 32'h0);
      chk("rst_cs", {31'b0, fb.FB_CS}, 32'h1);
      chk("rst_ale", {31'b0, fb.FB_ALE}, 32'h0);
      chk("rst_rw", {31'b0, fb.FB_RW}, 32'h1);
      chk("rst_ad_oe", {31'b0, dut.r_ad_oe}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Write, read, out-of-window (below base and one past the end), top word of window
      txn(1'b0, 32'h6000_0004, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
      txn(1'b1, 32'h6000_0010, 32'h0, 1'b0, 32'h1234_5678, 1'b0);
      txn(1'b0, 32'h5FFF_FFFC, 32'hAAAA_5555, 1'b1, 32'h0, 1'b0);
      txn(1'b1, 32'h6001_0000, 32'h0, 1'b1, 32'h0, 1'b0);
      txn(1'b0, 32'h6000_FFFC, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0);

      // Back-to-back with req_valid held: second ALE must follow after one IDLE cycle
      txn(1'b0, 32'h6000_0008, 32'h1111_2222, 1'b0, 32'h0, 1'b1);
      txn(1'b1, 32'h6000_000C, 32'h0, 1'b0, 32'h1234_5678, 1'b0);

      // Reset during the second data cycle of a write: no response may follow
      fb.req_valid = 1'b1;
      fb.req_rw    = 1'b0;
      fb.req_addr  = 32'h6000_0020;
      fb.req_wdata = 32'hCAFE_F00D;
      t = 0;
      while (!fb.req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      fb.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_cs", {31'b0, fb.FB_CS}, 32'h0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_cs", {31'b0, fb.FB_CS}, 32'h1);
      chk("midrst_ad_oe", {31'b0, dut.r_ad_oe}, 32'h0);
      chk("midrst_rsp_valid", {31'b0, fb.rsp_valid}, 32'h0);
      chk("midrst_ready", {31'b0, fb.req_ready}, 32'h1);
      chk("midrst_ale", {31'b0, fb.FB_ALE}, 32'h0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Loopback through the responder register at offset 0
      txn(1'b0, 32'h6000_0000, 32'h0000_03E8, 1'b0, 32'h0, 1'b0);
      txn(1'b1, 32'h6000_0000, 32'h0, 1'b0, 32'h0000_03E8, 1'b0);
      chk("loopback_reg0", resp_reg0_r, 32'h0000_03E8);

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
